// File: rtl/alu_pipe_ctrl_pkg.sv
// Shared encodings for the execute-stage pipeline controller: FSM states,
// forwarding source selects and the width of the branch-flush counter.
package alu_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PCS_RUN      = 2'd0,
    PCS_LU_STALL = 2'd1,
    PCS_BR_FLUSH = 2'd2,
    PCS_MEM_WAIT = 2'd3
  } pcs_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Holds BR_FLUSH_CYCLES-1, and BR_FLUSH_CYCLES is limited to 1..3.
  localparam int BR_CNT_W = 2;

endpackage

// File: rtl/alu_pipe_ctrl_if.sv
// Pipeline-side bundle of the execute-stage controller: hazard inputs,
// branch and memory status in; stall/flush/PC/forwarding controls out.
interface alu_pipe_ctrl_if #(
  parameter int REG_ADDR_W = 5
);

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;
  logic                  alu_bt;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  stall_if;
  logic                  stall_id;
  logic                  flush_id;
  logic                  flush_ex;
  logic                  pc_sel;
  logic [1:0]            fwd_rs;
  logic [1:0]            fwd_rt;
  logic [1:0]            state;

  // mem_req/mem_ready: mem_req is held while a data access is outstanding;
  // the access completes in the cycle where mem_ready is high with mem_req.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
           alu_bt, mem_req, mem_ready,
    input  stall_if, stall_id, flush_id, flush_ex, pc_sel,
           fwd_rs, fwd_rt, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
           alu_bt, mem_req, mem_ready,
    output stall_if, stall_id, flush_id, flush_ex, pc_sel,
           fwd_rs, fwd_rt, state
  );

endinterface

// File: rtl/alu_pipe_ctrl_fwd_sel.sv
// Forwarding comparator for one ALU operand: picks EX/MEM over MEM/WB over
// the register file, and never forwards register 0.
module fwd_sel
  import alu_pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
      fwd = FWD_EXMEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
      fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/alu_pipe_ctrl.sv
// Execute-stage sequencing controller: advance/stall/flush decisions, PC
// source and operand forwarding. ALU_PIPE_CTRL_PERF_EN adds stall/flush counters.
module alu_pipe_ctrl
  import alu_pipe_ctrl_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int REG_ADDR_W      = 5
) (
  input  logic clock,
  input  logic reset,
  alu_pipe_ctrl_if.slave bus
`ifdef ALU_PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [BR_CNT_W-1:0] BR_CNT_INIT = BR_CNT_W'(BR_FLUSH_CYCLES - 1);
  localparam pcs_state_e BR_NEXT = (BR_FLUSH_CYCLES > 1) ? PCS_BR_FLUSH : PCS_RUN;

  pcs_state_e            state_q, state_d;
  logic [BR_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  bt_pend_q, bt_pend_d;

  logic mem_wait, bt_now, lu_hazard;
  logic stall_if, stall_id, flush_id, flush_ex, pc_sel;
  logic [1:0] fwd_rs_raw, fwd_rt_raw;

  assign mem_wait  = bus.mem_req & ~bus.mem_ready;
  // A branch seen while memory stalled is replayed from bt_pend_q.
  assign bt_now    = bus.alu_bt | bt_pend_q;
  assign lu_hazard = bus.ex_mem_read && (bus.ex_rd != '0) &&
                     ((bus.ex_rd == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bt_pend_d = bt_pend_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    pc_sel    = 1'b0;

    case (state_q)
      PCS_RUN, PCS_LU_STALL: begin
        if (mem_wait) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bt_pend_d = bt_now;
          state_d   = PCS_MEM_WAIT;
        end else if (bt_now) begin
          pc_sel    = 1'b1;
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          bt_pend_d = 1'b0;
          cnt_d     = BR_CNT_INIT;
          state_d   = BR_NEXT;
        end else if ((state_q == PCS_RUN) && lu_hazard) begin
          // The bubble goes in once; LU_STALL does not re-check the same load.
          stall_if = 1'b1;
          flush_ex = 1'b1;
          state_d  = PCS_LU_STALL;
        end else begin
          state_d = PCS_RUN;
        end
      end
      PCS_BR_FLUSH: begin
        // Wrong-path instructions are squashed; their alu_bt is meaningless.
        flush_id = 1'b1;
        flush_ex = 1'b1;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= BR_CNT_W'(1)) state_d = PCS_RUN;
      end
      PCS_MEM_WAIT: begin
        if (bus.alu_bt) bt_pend_d = 1'b1;
        if (!bus.mem_ready) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end else begin
          state_d = PCS_RUN;
        end
      end
      default: state_d = PCS_RUN;
    endcase

    if (reset) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_id = 1'b1;
      flush_ex = 1'b1;
      pc_sel   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= PCS_RUN;
      cnt_q     <= '0;
      bt_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bt_pend_q <= bt_pend_d;
    end
  end

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src           (bus.id_rs),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .fwd           (fwd_rs_raw)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src           (bus.id_rt),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .fwd           (fwd_rt_raw)
  );

  assign bus.stall_if = stall_if;
  assign bus.stall_id = stall_id;
  assign bus.flush_id = flush_id;
  assign bus.flush_ex = flush_ex;
  assign bus.pc_sel   = pc_sel;
  assign bus.fwd_rs   = reset ? FWD_RF : fwd_rs_raw;
  assign bus.fwd_rt   = reset ? FWD_RF : fwd_rt_raw;
  assign bus.state    = state_q;

`ifdef ALU_PIPE_CTRL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_ex && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
